rvs_ooo: RTL and testbench
==========================

# rvs_ooo

Out-of-order reservation station for one execution unit. It accepts decoded instructions from dispatch and holds them until both source operands are captured. Operands arrive either with the instruction or from any of N_CDB common-data-bus broadcasts. Each cycle it issues the oldest ready entry (by ROB order), not just the entry at a FIFO head, and it supports a full pipeline flush. It sits between the decoder/dispatch stage and one EXU, and stalls dispatch through the ROB-busy input.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- TAG_W, 4: CDB/producer tag width; 0 means "no producer, operand valid".
- OPC_W, 4: opcode width.
- START_ID, 1: tag of entry 0; entry i owns tag START_ID+i; START_ID+DEPTH-1 < 2^TAG_W.
- ROB_DEPTH, 16: ROB entries; ROB_PTR_W = $clog2(ROB_DEPTH).
- N_CDB, 2: number of CDB broadcast ports.
- OFS_W, 12: immediate/offset width.
- clk in 1: single clock.
- rst in 1: asynchronous, active-low reset.
- flush in 1: synchronous kill of all entries.
- rob_head in ROB_PTR_W: inst_id of the oldest in-flight instruction.
- rob_busy in 1: ROB cannot accept; blocks dispatch.
- dis_req in 1: dispatch valid.
- dis_rdy out 1: station can accept.
- dis_tag out TAG_W: tag assigned to the instruction being dispatched.
- dis_opc in OPC_W; dis_inst_id in ROB_PTR_W; dis_offset in OFS_W.
- dis_src1_vld, dis_src2_vld in 1 each.
- dis_src1_tag, dis_src2_tag in TAG_W each.
- dis_src1_data, dis_src2_data in 32 each.
- cdb_wr in N_CDB: per-port broadcast valid.
- cdb_tag in N_CDB*TAG_W: port k occupies bits [k*TAG_W +: TAG_W].
- cdb_wdata in N_CDB*32: port k occupies bits [k*32 +: 32].
- iss_req out 1: an entry is ready to issue.
- iss_rdy in 1: EXU accepts.
- iss_tag out TAG_W; iss_opc out OPC_W; iss_src1, iss_src2 out 32; iss_offset out OFS_W; iss_inst_id out ROB_PTR_W.
- occupancy out $clog2(DEPTH)+1: number of busy entries.

## Operation
- Per-entry state: busy, vld1/vld2, tag1/tag2, src1/src2, opc, inst_id, offset.
- Allocation:
  - alloc slot = lowest-index non-busy entry.
  - dis_tag = alloc slot + START_ID; it is don't-care when the station is full.
  - dis_rdy = (any entry free) && !rob_busy && !flush.
  - Accept occurs on dis_req && dis_rdy: the slot becomes busy and its fields are loaded.
- Dispatch bypass:
  - If a dispatched source is not valid and its tag matches an active CDB port in the same cycle, that source is written valid with the CDB data.
  - A source tag of 0 is never matched by the CDB.
- Wakeup:
  - For each busy entry and each source with vld=0, a match on any active port sets vld=1, loads the data, and clears the tag to 0.
  - If several ports match the same tag, the lowest port index wins.
  - Valid sources ignore the CDB.
- Ready: busy && vld1 && vld2.
- Select:
  - Among ready entries, pick the one with the smallest age = (inst_id − rob_head) mod ROB_DEPTH.
  - On equal age, the lower index wins.
  - iss_* outputs show the selected entry; iss_tag = its index + START_ID.
- Issue:
  - On iss_req && iss_rdy, the selected entry's busy is cleared in that cycle's update.
  - That slot can be allocated again from the next cycle.
- Flush:
  - All busy and vld bits clear.
  - Dispatch and issue are ignored in the flush cycle.
  - iss_req is forced low while flush=1.
- Simultaneous issue and dispatch: the freed slot is not reused by the same-cycle dispatch. Allocation uses the pre-update busy vector.

## Timing
- Reset (rst=0, asynchronous): all busy/vld bits = 0, tags = 0, data = 0.
  - Outputs: iss_req=0, occupancy=0, dis_tag=START_ID.
  - dis_rdy=1 unless rob_busy=1.
- Dispatch accepted at cycle N with both sources valid (including via bypass): iss_req can assert at N+1.
- CDB broadcast at N wakes the last pending source: issue is possible at N+1.
- iss_* and dis_rdy are combinational from registered state plus rob_busy/flush/rob_head. No internal combinational path from the cdb_* inputs to iss_*.
- occupancy at N+1 = occupancy(N) + accept(N) − issue(N), or 0 after a flush.
- Full (occupancy=DEPTH): dis_rdy=0, even if an issue happens in the same cycle.
- Reset asserted mid-operation empties the station immediately; there is no drain.

## Test plan
- Reset, then dispatch 4 instructions with both sources valid (inst_id 3,4,5,6; rob_head=3) and iss_rdy=1 → tags 1,2,3,4, issued in order 1,2,3,4, one per cycle; occupancy returns to 0.
- Fill all entries with dis_src1_tag=5 pending → dis_rdy=0 and iss_req=0. Broadcast cdb_tag=5, wdata=0xDEADBEEF on port 1 → all entries become ready the next cycle, each issuing src1=0xDEADBEEF.
- Out-of-order issue: older entry inst_id=2 waits on tag 7; younger inst_id=5 is ready → inst_id 5 issues first. After tag 7 broadcasts, inst_id 2 issues next.
- Age wrap: rob_head=14, ready entries with inst_id 15 and 1 → 15 issues first.
- Same-cycle bypass: dispatch with src2_tag=6 while cdb port 0 broadcasts tag 6, data=0x1234 → iss_req=1 next cycle with iss_src2=0x1234. Two ports broadcast tag 6 with different data → the port 0 value is captured.
- Flush with 3 busy entries plus a concurrent dispatch → next cycle occupancy=0, iss_req=0, and the dispatched instruction is not stored. Asynchronous reset pulsed mid-traffic gives the same result immediately.

Source files
------------

// File: rtl/rvs_ooo.sv
// Out-of-order reservation station: holds dispatched instructions until both operands
// are captured (at dispatch or from CDB wakeup), then issues the oldest ready one by ROB age.
module rvs_ooo #(
  parameter  int unsigned DEPTH     = 4,
  parameter  int unsigned TAG_W     = 4,
  parameter  int unsigned OPC_W     = 4,
  parameter  int unsigned START_ID  = 1,
  parameter  int unsigned ROB_DEPTH = 16,
  parameter  int unsigned N_CDB     = 2,
  parameter  int unsigned OFS_W     = 12,
  localparam int unsigned ROB_PTR_W = $clog2(ROB_DEPTH),
  localparam int unsigned OCC_W     = $clog2(DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [ROB_PTR_W-1:0]    rob_head_i,
  input  logic                    rob_busy_i,
  input  logic                    dis_req_i,
  output logic                    dis_rdy_o,
  output logic [TAG_W-1:0]        dis_tag_o,
  input  logic [OPC_W-1:0]        dis_opc_i,
  input  logic [ROB_PTR_W-1:0]    dis_inst_id_i,
  input  logic [OFS_W-1:0]        dis_offset_i,
  input  logic                    dis_src1_vld_i,
  input  logic                    dis_src2_vld_i,
  input  logic [TAG_W-1:0]        dis_src1_tag_i,
  input  logic [TAG_W-1:0]        dis_src2_tag_i,
  input  logic [31:0]             dis_src1_data_i,
  input  logic [31:0]             dis_src2_data_i,
  input  logic [N_CDB-1:0]        cdb_wr_i,
  input  logic [N_CDB*TAG_W-1:0]  cdb_tag_i,
  input  logic [N_CDB*32-1:0]     cdb_wdata_i,
  output logic                    iss_req_o,
  input  logic                    iss_rdy_i,
  output logic [TAG_W-1:0]        iss_tag_o,
  output logic [OPC_W-1:0]        iss_opc_o,
  output logic [31:0]             iss_src1_o,
  output logic [31:0]             iss_src2_o,
  output logic [OFS_W-1:0]        iss_offset_o,
  output logic [ROB_PTR_W-1:0]    iss_inst_id_o,
  output logic [OCC_W-1:0]        occupancy_o
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     busy_q, busy_d, vld1_q, vld1_d, vld2_q, vld2_d, ready;
  logic [TAG_W-1:0]     tag1_q [DEPTH], tag1_d [DEPTH], tag2_q [DEPTH], tag2_d [DEPTH];
  logic [31:0]          src1_q [DEPTH], src1_d [DEPTH], src2_q [DEPTH], src2_d [DEPTH];
  logic [OPC_W-1:0]     opc_q  [DEPTH], opc_d  [DEPTH];
  logic [ROB_PTR_W-1:0] iid_q  [DEPTH], iid_d  [DEPTH];
  logic [OFS_W-1:0]     ofs_q  [DEPTH], ofs_d  [DEPTH];

  logic [IDX_W-1:0]     alloc_idx, sel_idx;
  logic                 any_free, sel_vld, accept, fire;
  logic [ROB_PTR_W-1:0] age, best_age;
  logic [32:0]          hit1, hit2;

  // Returns {hit, data}; lower port index wins, tag 0 never matches.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0] t,
                                             input logic [N_CDB-1:0] wr,
                                             input logic [N_CDB*TAG_W-1:0] tags,
                                             input logic [N_CDB*32-1:0] data);
    logic [32:0] r;
    r = '0;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (wr[k] && (t != '0) && (tags[k*TAG_W +: TAG_W] == t)) r = {1'b1, data[k*32 +: 32]};
    end
    return r;
  endfunction

  assign ready = busy_q & vld1_q & vld2_q;

  // Lowest-index free slot.
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_idx = IDX_W'(i);
        any_free  = 1'b1;
      end
    end
  end

  // Oldest ready entry by ROB distance from head; strict compare keeps the lower index on ties.
  always_comb begin
    sel_idx  = '0;
    sel_vld  = 1'b0;
    best_age = '0;
    age      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = iid_q[i] - rob_head_i;
      if (ready[i] && (!sel_vld || (age < best_age))) begin
        sel_vld  = 1'b1;
        best_age = age;
        sel_idx  = IDX_W'(i);
      end
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < DEPTH; i++) occupancy_o = occupancy_o + OCC_W'(busy_q[i]);
  end

  assign dis_rdy_o     = any_free && !rob_busy_i && !flush_i;
  assign dis_tag_o     = TAG_W'(alloc_idx) + TAG_W'(START_ID);
  assign iss_req_o     = sel_vld && !flush_i;
  assign iss_tag_o     = TAG_W'(sel_idx) + TAG_W'(START_ID);
  assign iss_opc_o     = opc_q[sel_idx];
  assign iss_src1_o    = src1_q[sel_idx];
  assign iss_src2_o    = src2_q[sel_idx];
  assign iss_offset_o  = ofs_q[sel_idx];
  assign iss_inst_id_o = iid_q[sel_idx];
  assign accept        = dis_req_i && dis_rdy_o;
  assign fire          = iss_req_o && iss_rdy_i;

  // Next state: wakeup, issue, allocate with bypass, then flush overrides.
  always_comb begin
    busy_d = busy_q;
    vld1_d = vld1_q;
    vld2_d = vld2_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    src1_d = src1_q;
    src2_d = src2_q;
    opc_d  = opc_q;
    iid_d  = iid_q;
    ofs_d  = ofs_q;
    hit1   = '0;
    hit2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = cdb_lookup(tag1_q[i], cdb_wr_i, cdb_tag_i, cdb_wdata_i);
      hit2 = cdb_lookup(tag2_q[i], cdb_wr_i, cdb_tag_i, cdb_wdata_i);
      if (busy_q[i] && !vld1_q[i] && hit1[32]) begin
        vld1_d[i] = 1'b1;
        src1_d[i] = hit1[31:0];
        tag1_d[i] = '0;
      end
      if (busy_q[i] && !vld2_q[i] && hit2[32]) begin
        vld2_d[i] = 1'b1;
        src2_d[i] = hit2[31:0];
        tag2_d[i] = '0;
      end
      if (fire && (sel_idx == IDX_W'(i))) busy_d[i] = 1'b0;
      if (accept && (alloc_idx == IDX_W'(i))) begin
        hit1      = cdb_lookup(dis_src1_tag_i, cdb_wr_i, cdb_tag_i, cdb_wdata_i);
        hit2      = cdb_lookup(dis_src2_tag_i, cdb_wr_i, cdb_tag_i, cdb_wdata_i);
        busy_d[i] = 1'b1;
        opc_d[i]  = dis_opc_i;
        iid_d[i]  = dis_inst_id_i;
        ofs_d[i]  = dis_offset_i;
        vld1_d[i] = dis_src1_vld_i || hit1[32];
        vld2_d[i] = dis_src2_vld_i || hit2[32];
        src1_d[i] = dis_src1_vld_i ? dis_src1_data_i : hit1[31:0];
        src2_d[i] = dis_src2_vld_i ? dis_src2_data_i : hit2[31:0];
        tag1_d[i] = (dis_src1_vld_i || hit1[32]) ? '0 : dis_src1_tag_i;
        tag2_d[i] = (dis_src2_vld_i || hit2[32]) ? '0 : dis_src2_tag_i;
      end
    end
    if (flush_i) begin
      busy_d = '0;
      vld1_d = '0;
      vld2_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      vld1_q <= '0;
      vld2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        src1_q[i] <= '0;
        src2_q[i] <= '0;
        opc_q[i]  <= '0;
        iid_q[i]  <= '0;
        ofs_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      vld1_q <= vld1_d;
      vld2_q <= vld2_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag1_q[i] <= tag1_d[i];
        tag2_q[i] <= tag2_d[i];
        src1_q[i] <= src1_d[i];
        src2_q[i] <= src2_d[i];
        opc_q[i]  <= opc_d[i];
        iid_q[i]  <= iid_d[i];
        ofs_q[i]  <= ofs_d[i];
      end
    end
  end
endmodule

// File: tb/tb_rvs_ooo.sv
// Bench for rvs_ooo: directed scenarios plus random traffic, scored against an entry-level model.
module tb_rvs_ooo;
  localparam int DEPTH = 4, TAG_W = 4, OPC_W = 4, START_ID = 1, ROB_DEPTH = 16;
  localparam int N_CDB = 2, OFS_W = 12, RPW = 4, OCC_W = 3;

  logic clk = 1'b0;
  logic rst_n, flush, rob_busy, dis_req, dis_rdy, iss_req, iss_rdy;
  logic [RPW-1:0] rob_head, dis_inst_id, iss_inst_id;
  logic [TAG_W-1:0] dis_tag, dis_src1_tag, dis_src2_tag, iss_tag;
  logic [OPC_W-1:0] dis_opc, iss_opc;
  logic [OFS_W-1:0] dis_offset, iss_offset;
  logic dis_src1_vld, dis_src2_vld;
  logic [31:0] dis_src1_data, dis_src2_data, iss_src1, iss_src2;
  logic [N_CDB-1:0] cdb_wr;
  logic [N_CDB*TAG_W-1:0] cdb_tag;
  logic [N_CDB*32-1:0] cdb_wdata;
  logic [OCC_W-1:0] occupancy;

  rvs_ooo dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rob_head_i(rob_head), .rob_busy_i(rob_busy),
    .dis_req_i(dis_req), .dis_rdy_o(dis_rdy), .dis_tag_o(dis_tag), .dis_opc_i(dis_opc),
    .dis_inst_id_i(dis_inst_id), .dis_offset_i(dis_offset),
    .dis_src1_vld_i(dis_src1_vld), .dis_src2_vld_i(dis_src2_vld),
    .dis_src1_tag_i(dis_src1_tag), .dis_src2_tag_i(dis_src2_tag),
    .dis_src1_data_i(dis_src1_data), .dis_src2_data_i(dis_src2_data),
    .cdb_wr_i(cdb_wr), .cdb_tag_i(cdb_tag), .cdb_wdata_i(cdb_wdata),
    .iss_req_o(iss_req), .iss_rdy_i(iss_rdy), .iss_tag_o(iss_tag), .iss_opc_o(iss_opc),
    .iss_src1_o(iss_src1), .iss_src2_o(iss_src2), .iss_offset_o(iss_offset),
    .iss_inst_id_o(iss_inst_id), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit busy, v1, v2;
    int t1, t2, opc, iid, ofs;
    bit [31:0] d1, d2;
  } ent_t;

  typedef struct {
    bit req, rdy;
    int tag, opc, iid, ofs, occ, dtag;
    bit [31:0] s1, s2;
  } exp_t;

  ent_t m[DEPTH];
  exp_t q[$];

  // First active CDB port carrying tag t, if any.
  function automatic bit cdb_find(input int t, output bit [31:0] d);
    d = 0;
    if (t == 0) return 1'b0;
    for (int k = 0; k < N_CDB; k++)
      if (cdb_wr[k] && int'(cdb_tag[k*TAG_W +: TAG_W]) == t) begin
        d = cdb_wdata[k*32 +: 32];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  // Reference model: predicts this cycle's outputs from stored entries, then advances them.
  always @(negedge clk) begin
    exp_t e;
    int sel, best, age, alloc, occ;
    bit [31:0] d;
    if (!rst_n) foreach (m[i]) m[i] = '{default: 0};
    sel = -1; best = ROB_DEPTH; alloc = -1; occ = 0;
    foreach (m[i]) begin
      if (m[i].busy) occ++;
      else if (alloc < 0) alloc = i;
      if (m[i].busy && m[i].v1 && m[i].v2) begin
        age = (m[i].iid - int'(rob_head) + ROB_DEPTH) % ROB_DEPTH;
        if (age < best) begin best = age; sel = i; end
      end
    end
    e = '{default: 0};
    e.req = (sel >= 0) && !flush;
    if (sel >= 0) begin
      e.tag = sel + START_ID; e.opc = m[sel].opc; e.iid = m[sel].iid; e.ofs = m[sel].ofs;
      e.s1 = m[sel].d1; e.s2 = m[sel].d2;
    end
    e.occ = occ;
    e.rdy = (alloc >= 0) && !rob_busy && !flush;
    e.dtag = alloc + START_ID;
    q.push_back(e);
    if (rst_n) begin
      foreach (m[i]) if (m[i].busy) begin
        if (!m[i].v1 && cdb_find(m[i].t1, d)) begin m[i].v1 = 1; m[i].d1 = d; m[i].t1 = 0; end
        if (!m[i].v2 && cdb_find(m[i].t2, d)) begin m[i].v2 = 1; m[i].d2 = d; m[i].t2 = 0; end
      end
      if (e.req && iss_rdy) m[sel].busy = 0;
      if (dis_req && e.rdy) begin
        m[alloc].busy = 1; m[alloc].opc = int'(dis_opc); m[alloc].iid = int'(dis_inst_id);
        m[alloc].ofs = int'(dis_offset);
        m[alloc].v1 = dis_src1_vld; m[alloc].d1 = dis_src1_data; m[alloc].t1 = int'(dis_src1_tag);
        m[alloc].v2 = dis_src2_vld; m[alloc].d2 = dis_src2_data; m[alloc].t2 = int'(dis_src2_tag);
        if (!dis_src1_vld && cdb_find(m[alloc].t1, d)) begin m[alloc].v1 = 1; m[alloc].d1 = d; end
        if (!dis_src2_vld && cdb_find(m[alloc].t2, d)) begin m[alloc].v2 = 1; m[alloc].d2 = d; end
        if (m[alloc].v1) m[alloc].t1 = 0;
        if (m[alloc].v2) m[alloc].t2 = 0;
      end
      if (flush) foreach (m[i]) begin m[i].busy = 0; m[i].v1 = 0; m[i].v2 = 0; end
    end
  end

  // Monitor: compares DUT outputs with the queued prediction for the same cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("iss_req", 32'(iss_req), 32'(e.req));
      if (e.req && iss_req) begin
        chk("iss_tag", 32'(iss_tag), 32'(e.tag));
        chk("iss_opc", 32'(iss_opc), 32'(e.opc));
        chk("iss_inst_id", 32'(iss_inst_id), 32'(e.iid));
        chk("iss_offset", 32'(iss_offset), 32'(e.ofs));
        chk("iss_src1", iss_src1, e.s1);
        chk("iss_src2", iss_src2, e.s2);
      end
      chk("occupancy", 32'(occupancy), 32'(e.occ));
      chk("dis_rdy", 32'(dis_rdy), 32'(e.rdy));
      if (e.occ < DEPTH) chk("dis_tag", 32'(dis_tag), 32'(e.dtag));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dis_req = 0; cdb_wr = '0; flush = 0;
  endtask

  task automatic dis(input int opc, input int iid, input int ofs,
                     input bit v1, input int t1, input logic [31:0] d1,
                     input bit v2, input int t2, input logic [31:0] d2);
    dis_req = 1; dis_opc = OPC_W'(opc); dis_inst_id = RPW'(iid); dis_offset = OFS_W'(ofs);
    dis_src1_vld = v1; dis_src1_tag = TAG_W'(t1); dis_src1_data = d1;
    dis_src2_vld = v2; dis_src2_tag = TAG_W'(t2); dis_src2_data = d2;
  endtask

  task automatic bcast(input int k, input int t, input logic [31:0] d);
    cdb_wr[k] = 1'b1;
    cdb_tag[k*TAG_W +: TAG_W] = TAG_W'(t);
    cdb_wdata[k*32 +: 32] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; flush = 0; rob_head = '0; rob_busy = 0; iss_rdy = 0;
    dis(0, 0, 0, 1, 0, 0, 1, 0, 0); dis_req = 0;
    cdb_wr = '0; cdb_tag = '0; cdb_wdata = '0;
    tick(); tick();
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_iss_req", 32'(iss_req), 0);
    chk("rst_dis_tag", 32'(dis_tag), START_ID);
    chk("rst_dis_rdy", 32'(dis_rdy), 1);
    rob_busy = 1; #1;
    chk("rob_busy_blocks", 32'(dis_rdy), 0);
    rob_busy = 0;
    tick(); rst_n = 1; tick();

    // In-order fill then drain.
    rob_head = 3;
    for (int i = 0; i < 4; i++) begin
      dis(i + 1, 3 + i, 16 * i, 1, 0, 32'h100 + i, 1, 0, 32'h200 + i);
      #1 chk("fill_dis_tag", 32'(dis_tag), 32'(i + START_ID));
      tick();
    end
    idle(); iss_rdy = 1;
    repeat (6) tick();

    // All entries wait on tag 5; one broadcast wakes them all.
    for (int i = 0; i < 4; i++) begin
      dis(8 + i, 3 + i, i, 0, 5, 0, 1, 0, 32'h55 + i); tick();
    end
    idle();
    chk("full_dis_rdy", 32'(dis_rdy), 0);
    chk("pending_iss_req", 32'(iss_req), 0);
    bcast(1, 5, 32'hDEADBEEF); tick(); idle();
    chk("wake_iss_req", 32'(iss_req), 1);
    chk("wake_src1", iss_src1, 32'hDEADBEEF);
    repeat (6) tick();

    // Younger ready entry overtakes older waiting one.
    rob_head = 1; iss_rdy = 0;
    dis(1, 2, 1, 0, 7, 0, 1, 0, 32'h2); tick();
    dis(2, 5, 2, 1, 0, 32'h5, 1, 0, 32'h5); tick();
    idle(); iss_rdy = 1; #1;
    chk("ooo_first", 32'(iss_inst_id), 5);
    tick(); tick();
    bcast(0, 7, 32'h77); tick(); idle();
    chk("ooo_second", 32'(iss_inst_id), 2);
    repeat (3) tick();

    // Age wrap around the ROB.
    rob_head = 14; iss_rdy = 0;
    dis(3, 1, 0, 1, 0, 32'h1, 1, 0, 32'h1); tick();
    dis(4, 15, 0, 1, 0, 32'hF, 1, 0, 32'hF); tick();
    idle(); iss_rdy = 1; #1;
    chk("wrap_first", 32'(iss_inst_id), 15);
    repeat (4) tick();

    // Same-cycle bypass, then conflicting ports.
    dis(5, 14, 0, 1, 0, 32'h9, 0, 6, 0); bcast(0, 6, 32'h1234); tick(); idle();
    chk("bypass_src2", iss_src2, 32'h1234);
    dis(6, 14, 0, 1, 0, 32'h9, 0, 6, 0); bcast(0, 6, 32'hAAAA); bcast(1, 6, 32'hBBBB);
    tick(); idle();
    chk("bypass_port0_wins", iss_src2, 32'hAAAA);
    repeat (3) tick();

    // Flush with concurrent dispatch.
    iss_rdy = 0;
    for (int i = 0; i < 3; i++) begin dis(i, i, 0, 1, 0, 1, 1, 0, 1); tick(); end
    dis(9, 9, 0, 1, 0, 1, 1, 0, 1); flush = 1; tick(); idle(); #1;
    chk("flush_occupancy", 32'(occupancy), 0);
    chk("flush_iss_req", 32'(iss_req), 0);
    tick();
    for (int i = 0; i < 2; i++) begin dis(i, i, 0, 1, 0, 1, 1, 0, 1); tick(); end
    idle(); rst_n = 0; #1;
    chk("async_rst_occupancy", 32'(occupancy), 0);
    chk("async_rst_iss_req", 32'(iss_req), 0);
    tick(); rst_n = 1; tick();

    // Random traffic.
    repeat (3000) begin
      dis($urandom, $urandom, $urandom, ($urandom % 3) != 0, $urandom_range(1, 7), $urandom,
          ($urandom % 3) != 0, $urandom_range(1, 7), $urandom);
      dis_req = ($urandom % 2) != 0;
      cdb_wr = '0;
      for (int k = 0; k < N_CDB; k++) if (($urandom % 3) == 0) bcast(k, $urandom_range(1, 7), $urandom);
      iss_rdy = ($urandom % 4) != 0;
      rob_busy = ($urandom % 8) == 0;
      flush = ($urandom % 64) == 0;
      if (($urandom % 16) == 0) rob_head = RPW'($urandom);
      tick();
    end
    idle(); rob_busy = 0; flush = 1; tick(); flush = 0;
    repeat (2) tick();
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
